// File: rtl/alu_taylor_eval.sv
// Sequential Taylor-series evaluator: walks the coefficient table term by term and
// accumulates a0 + t1 + ... + tN through a single shared 18x18 signed multiplier.
module alu_taylor_eval #(
  parameter int unsigned N_TERMS = 11,
  parameter int unsigned IDX_W   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       function_sel,
  input  logic [17:0]      x,
  output logic             busy,
  output logic             done,
  output logic [17:0]      result,
  output logic [2:0]       coef_fsel,
  output logic [IDX_W-1:0] coef_idx,
  input  logic [17:0]      coef_deriv,
  input  logic [17:0]      coef_a0
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_MUL_X = 3'd2;
  localparam logic [2:0] S_MUL_C = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]         state_q, state_d;
  logic signed [17:0] x_q, x_d;
  logic signed [17:0] term_q, term_d;
  logic signed [17:0] acc_q, acc_d;
  logic signed [17:0] p_q, p_d;
  logic signed [17:0] result_q, result_d;
  logic [2:0]         fsel_q, fsel_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic signed [17:0] mul_a, mul_b;
  logic signed [35:0] prod;
  logic signed [17:0] prod_sat;
  logic signed [35:0] sum;
  logic signed [17:0] sum_sat;

  function automatic logic signed [17:0] sat18(input logic signed [35:0] v);
    if (v > 36'sd131071)
      return {1'b0, {17{1'b1}}};
    else if (v < -36'sd131072)
      return {1'b1, {17{1'b0}}};
    else
      return v[17:0];
  endfunction

  // Arithmetic shift floors, matching the Q2.16 truncation of the product.
  assign prod     = mul_a * mul_b;
  assign prod_sat = sat18(prod >>> 16);
  assign sum      = 36'(acc_q) + 36'(prod_sat);
  assign sum_sat  = sat18(sum);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    term_d   = term_q;
    acc_d    = acc_q;
    p_d      = p_q;
    result_d = result_q;
    fsel_d   = fsel_q;
    idx_d    = idx_q;
    mul_a    = '0;
    mul_b    = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = x;
          fsel_d  = function_sel;
          idx_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        term_d  = coef_a0;
        acc_d   = coef_a0;
        state_d = S_MUL_X;
      end
      S_MUL_X: begin
        // result is loaded on entry to DONE so it is already valid while done is high
        if (coef_deriv == '0) begin
          result_d = acc_q;
          state_d  = S_DONE;
        end else begin
          mul_a   = term_q;
          mul_b   = x_q;
          p_d     = prod_sat;
          state_d = S_MUL_C;
        end
      end
      S_MUL_C: begin
        mul_a  = p_q;
        mul_b  = coef_deriv;
        term_d = prod_sat;
        acc_d  = sum_sat;
        if (idx_q == IDX_W'(N_TERMS - 1)) begin
          result_d = sum_sat;
          state_d  = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_MUL_X;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      term_q   <= '0;
      acc_q    <= '0;
      p_q      <= '0;
      result_q <= '0;
      fsel_q   <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      term_q   <= term_d;
      acc_q    <= acc_d;
      p_q      <= p_d;
      result_q <= result_d;
      fsel_q   <= fsel_d;
      idx_q    <= idx_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign coef_fsel = fsel_q;
  assign coef_idx  = idx_q;

endmodule

// File: tb/tb_alu_taylor_eval.sv
// Bench for alu_taylor_eval: a behavioural coefficient table plus a plain-arithmetic
// Taylor-sum model predicting result and done latency for directed and random runs.
module tb_alu_taylor_eval;

  localparam int N = 11;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  function_sel;
  logic [17:0] x;
  logic        busy;
  logic        done;
  logic [17:0] result;
  logic [2:0]  coef_fsel;
  logic [3:0]  coef_idx;
  logic [17:0] coef_deriv;
  logic [17:0] coef_a0;

  logic [17:0] a0_tab    [8];
  logic [17:0] deriv_tab [8][16];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign coef_a0    = a0_tab[coef_fsel];
  assign coef_deriv = deriv_tab[coef_fsel][coef_idx];

  alu_taylor_eval #(.N_TERMS(N), .IDX_W(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .function_sel (function_sel),
    .x            (x),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .coef_fsel    (coef_fsel),
    .coef_idx     (coef_idx),
    .coef_deriv   (coef_deriv),
    .coef_a0      (coef_a0)
  );

  task automatic check_eq(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > 131071)  return 131071;
    if (v < -131072) return -131072;
    return v;
  endfunction

  // Taylor sum from the table with Q2.16 floor scaling and saturation at every step.
  task automatic model(input logic [2:0] fs, input logic [17:0] xv,
                       output logic [17:0] r, output int lat);
    longint term, acc, xs, p, t, d;
    xs   = $signed(xv);
    term = $signed(a0_tab[fs]);
    acc  = term;
    lat  = 2 * N + 1;
    for (int k = 0; k < N; k++) begin
      d = $signed(deriv_tab[fs][k]);
      if (d == 0) begin
        lat = 2 * k + 2;
        break;
      end
      p    = sat((term * xs) >>> 16);
      t    = sat((p * d) >>> 16);
      term = t;
      acc  = sat(acc + t);
    end
    r = acc[17:0];
  endtask

  // Edge 0 samples start; edges are numbered from there. Optional extra start pulse
  // and reset pulse are applied so they are sampled at the given edge.
  task automatic run_op(input string name, input logic [2:0] fs, input logic [17:0] xv,
                        input int pulse_at, input int rst_at);
    logic [17:0] exp_r;
    int          exp_e;
    int          ndone;
    logic [17:0] hold_exp;
    model(fs, xv, exp_r, exp_e);
    ndone = 0;
    @(negedge clk);
    start        = 1'b1;
    function_sel = fs;
    x            = xv;
    @(posedge clk);
    #1;
    check_eq({name, ".busy0"}, busy, 1);
    @(negedge clk);
    start        = 1'b0;
    function_sel = 3'($urandom);
    x            = 18'($urandom);
    for (int e = 1; e <= 60; e++) begin
      if (e == pulse_at) start = 1'b1;
      if (e == rst_at) reset_n = 1'b0;
      @(posedge clk);
      #1;
      if (done) ndone++;
      if (rst_at >= 0 && e >= rst_at) begin
        check_eq({name, ".rst_busy"}, busy, 0);
        check_eq({name, ".rst_done"}, done, 0);
        if (e == rst_at) begin
          check_eq({name, ".rst_result"}, result, 0);
          check_eq({name, ".rst_idx"}, coef_idx, 0);
          check_eq({name, ".rst_fsel"}, coef_fsel, 0);
        end
      end else begin
        check_eq({name, ".busy"}, busy, (e <= exp_e) ? 1 : 0);
        check_eq({name, ".done"}, done, (e == exp_e) ? 1 : 0);
        if (e == 1) check_eq({name, ".fsel"}, coef_fsel, fs);
        if (done) check_eq({name, ".result"}, result, exp_r);
      end
      @(negedge clk);
      start   = 1'b0;
      reset_n = 1'b1;
    end
    hold_exp = (rst_at >= 0) ? 18'h0 : exp_r;
    check_eq({name, ".ndone"}, ndone, (rst_at >= 0) ? 0 : 1);
    check_eq({name, ".hold"}, result, hold_exp);
  endtask

  initial begin
    logic [2:0] fs;
    reset_n      = 1'b0;
    start        = 1'b0;
    function_sel = '0;
    x            = '0;
    for (int f = 0; f < 8; f++) begin
      a0_tab[f] = 18'($urandom);
      for (int k = 0; k < 16; k++) deriv_tab[f][k] = 18'($urandom);
    end
    a0_tab[1] = 18'h10000;
    a0_tab[2] = 18'h0C000;
    for (int k = 0; k < 16; k++) begin
      deriv_tab[1][k] = 18'h10000;
      deriv_tab[2][k] = 18'h00000;
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset.busy", busy, 0);
    check_eq("reset.done", done, 0);
    check_eq("reset.result", result, 0);
    check_eq("reset.idx", coef_idx, 0);
    check_eq("reset.fsel", coef_fsel, 0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op("half",      3'd1, 18'h08000, -1, -1);
    run_op("one_sat",   3'd1, 18'h10000, -1, -1);
    run_op("minus_one", 3'd1, 18'h30000, -1, -1);
    run_op("early",     3'd2, 18'($urandom), -1, -1);
    run_op("pulse5",    3'd1, 18'h08000, 5, -1);
    run_op("pulse_dn",  3'd1, 18'h04000, 2 * N + 2, -1);
    run_op("reset10",   3'd1, 18'h08000, -1, 10);
    run_op("restart",   3'd1, 18'h08000, -1, -1);

    for (int i = 0; i < 25; i++) begin
      fs = 3'($urandom_range(3, 7));
      a0_tab[fs] = 18'($urandom);
      for (int k = 0; k < 16; k++)
        deriv_tab[fs][k] = ($urandom_range(0, 7) == 0) ? 18'h0 : 18'($urandom);
      run_op("rand", fs, 18'($urandom), -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
